// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
//   Central reset controller for the OrangeCrab fabric. It accepts reset
//   requests from the button front end (short press = system reset, long
//   press = boot reset) and from a software register bit. It holds every
//   downstream domain in reset for ASSERT_CLKS cycles, then releases the
//   domains one at a time, lowest index first, STAGE_DELAY_CLKS apart. A boot
//   request parks the block in a terminal BOOT state that drives boot_rst.
//
// Ports
//   clk           system clock (48 MHz)
//   rst           asynchronous active-high reset
//   btn_rst_req   short-press request, acted on at its rising edge
//   btn_boot_req  long-press request, acted on at its rising edge
//   sw_rst_req    software request, acted on at its rising edge
//   domain_rst    per-domain active-high reset, bit 0 released first
//   boot_rst      bootloader reboot request (terminal)
//   busy          high while any domain is held in reset
//   rst_cause     last accepted source: 0 POR, 1 button, 2 software, 3 boot
// ---------------------------------------------------------------------------
module rst_sequencer #(
    parameter int NUM_DOMAINS      = 3,
    parameter int ASSERT_CLKS      = 480000,
    parameter int STAGE_DELAY_CLKS = 48,
    parameter int CNT_WL           = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_rst_req,
    input  logic                   btn_boot_req,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   boot_rst,
    output logic                   busy,
    output logic [1:0]             rst_cause
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_IDLE    = 2'd2;
    localparam logic [1:0] ST_BOOT    = 2'd3;

    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_BOOT = 2'd3;

    // Index must be able to hold NUM_DOMAINS-1 plus the post-increment value.
    localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_WL-1:0] ASSERT_LAST = CNT_WL'(ASSERT_CLKS - 1);
    localparam logic [CNT_WL-1:0] STAGE_LAST  = CNT_WL'(STAGE_DELAY_CLKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_WL-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   boot_q, boot_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cause_q, cause_d;

    // Previous-value flops for edge detection: {boot, btn, sw}.
    logic [2:0]             prev_q;

    logic btn_edge, boot_edge, sw_edge;
    logic [NUM_DOMAINS-1:0] rel_mask;

    assign btn_edge  = btn_rst_req  & ~prev_q[1];
    assign boot_edge = btn_boot_req & ~prev_q[2];
    assign sw_edge   = sw_rst_req   & ~prev_q[0];

    // One-hot mask selecting the domain released at the current stage.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel_mask
            assign rel_mask[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        boot_d  = boot_q;
        busy_d  = busy_q;
        cause_d = cause_q;

        if (state_q != ST_BOOT && boot_edge) begin
            state_d = ST_BOOT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            boot_d  = 1'b1;
            busy_d  = 1'b1;
            cause_d = CAUSE_BOOT;
        end else if ((state_q == ST_IDLE || state_q == ST_RELEASE) &&
                     (btn_edge || sw_edge)) begin
            // Re-asserts every domain, including ones already released.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '1;
            busy_d  = 1'b1;
            cause_d = btn_edge ? CAUSE_BTN : CAUSE_SW;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == ASSERT_LAST) begin
                        cnt_d = '0;
                        dom_d = dom_q & ~NUM_DOMAINS'(1);
                        if (NUM_DOMAINS == 1) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d = '0;
                        dom_d = dom_q & ~rel_mask;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            boot_q  <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 2'd0;
            // High so a request held through reset is not seen as an edge.
            prev_q  <= 3'b111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            boot_q  <= boot_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            prev_q  <= {btn_boot_req, btn_rst_req, sw_rst_req};
        end
    end

    assign domain_rst = dom_q;
    assign boot_rst   = boot_q;
    assign busy       = busy_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
//   Scoreboard bench for rst_sequencer with ASSERT_CLKS=8, STAGE_DELAY_CLKS=4,
//   NUM_DOMAINS=3. Each stimulus pushes the per-edge expected outputs into a
//   queue; a negedge monitor pops the entry for the current edge and compares.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;

    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_rst_req = 1'b0;
    logic          btn_boot_req = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic [ND-1:0] domain_rst;
    logic          boot_rst;
    logic          busy;
    logic [1:0]    rst_cause;

    rst_sequencer #(
        .NUM_DOMAINS      (ND),
        .ASSERT_CLKS      (8),
        .STAGE_DELAY_CLKS (4),
        .CNT_WL           (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_rst_req  (btn_rst_req),
        .btn_boot_req (btn_boot_req),
        .sw_rst_req   (sw_rst_req),
        .domain_rst   (domain_rst),
        .boot_rst     (boot_rst),
        .busy         (busy),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [ND-1:0] dom;
        logic          bsy;
        logic          boot;
        logic [1:0]    cause;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Drop expectations from edge d onward (a later event supersedes them).
    task automatic flush_from(input int d);
        while (sb.size() > 0 && sb[$].cyc >= d) void'(sb.pop_back());
    endtask

    // Reset sequence: state entered ASSERT with counter 0 at edge 'base'.
    // Domain k falls at base+8+4k; busy falls with the last domain.
    task automatic push_seq(input int base, input int first_off, input logic [1:0] cause);
        exp_t e;
        for (int off = first_off; off <= 18; off++) begin
            e.cyc   = base + off;
            e.boot  = 1'b0;
            e.cause = cause;
            if (off < 8)       e.dom = 3'b111;
            else if (off < 12) e.dom = 3'b110;
            else if (off < 16) e.dom = 3'b100;
            else               e.dom = 3'b000;
            e.bsy = (off < 16);
            sb.push_back(e);
        end
    endtask

    task automatic push_boot(input int base);
        exp_t e;
        for (int off = 0; off <= 10; off++) begin
            e.cyc   = base + off;
            e.dom   = 3'b111;
            e.bsy   = 1'b1;
            e.boot  = 1'b1;
            e.cause = 2'd3;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
                exp_t e;
                e = sb.pop_front();
                check("domain_rst", 32'(domain_rst), 32'(e.dom));
                check("busy",       32'(busy),       32'(e.bsy));
                check("boot_rst",   32'(boot_rst),   32'(e.boot));
                check("rst_cause",  32'(rst_cause),  32'(e.cause));
            end
        end
    end

    task automatic wait_drain();
        int b = 0;
        while (sb.size() > 0 && b < 200) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Pulse rst between edges; reset-state outputs checked while rst is high.
    task automatic do_por(input logic hold_btn);
        @(negedge clk);
        rst = 1'b1;
        btn_rst_req = hold_btn;
        #1;
        check("por_dom",   32'(domain_rst), 32'h7);
        check("por_busy",  32'(busy),       32'd1);
        check("por_boot",  32'(boot_rst),   32'd0);
        check("por_cause", 32'(rst_cause),  32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        push_seq(edge_n, 1, 2'd0);
        $display("txn: POR released after edge %0d (btn held=%0b)", edge_n, hold_btn);
    endtask

    // Raise the selected requests for one cycle; detection edge returned.
    task automatic pulse(input logic b, input logic bt, input logic s, output int d);
        @(negedge clk);
        btn_rst_req  = b;
        btn_boot_req = bt;
        sw_rst_req   = s;
        d = edge_n + 1;
        $display("txn: request btn=%0b boot=%0b sw=%0b detected at edge %0d", b, bt, s, d);
    endtask

    task automatic release_all();
        @(negedge clk);
        btn_rst_req  = 1'b0;
        btn_boot_req = 1'b0;
        sw_rst_req   = 1'b0;
    endtask

    initial begin
        int d;

        // Test 1: POR sequence.
        do_por(1'b0);
        wait_drain();

        // Test 2: button reset from IDLE.
        pulse(1'b1, 1'b0, 1'b0, d);
        flush_from(d);
        push_seq(d, 0, 2'd1);
        release_all();

        // Test 3: software reset between release of domain 0 and domain 1.
        repeat (8) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1, d);
        flush_from(d);
        push_seq(d, 0, 2'd2);
        release_all();
        wait_drain();

        // Test 4: simultaneous boot + button, boot wins; later button ignored.
        pulse(1'b1, 1'b1, 1'b0, d);
        flush_from(d);
        push_boot(d);
        release_all();
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0, d);
        flush_from(d);
        push_boot(d);
        release_all();
        wait_drain();
        do_por(1'b0);
        wait_drain();

        // Test 5: button edge while ASSERT counter is 3 is ignored.
        do_por(1'b0);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0, d);
        release_all();
        wait_drain();

        // Test 6: button held through reset is not an edge; a fresh one is.
        do_por(1'b1);
        wait_drain();
        @(negedge clk);
        btn_rst_req = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, d);
        flush_from(d);
        push_seq(d, 0, 2'd1);
        release_all();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
